sync_fifo_param: RTL and testbench

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

---
 rtl/sync_fifo_param.sv | 144 ++++++++++++++
 tb/tb_sync_fifo_param.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock parameterised FIFO with registered read data
//
// Purpose:
//   Synchronous FIFO, DEPTH entries of WIDTH bits. A write is accepted when
//   w_en=1 and the FIFO is not full. A read is accepted when r_en=1 and the
//   FIFO is not empty. Read data is registered and appears on dout one cycle
//   after the accepting edge, and it holds its value otherwise. All status
//   flags are decoded combinationally from the occupancy counter.
//
// Parameters:
//   WIDTH     data word width (1..64)
//   DEPTH     number of entries, power of two (4..1024)
//   AF_LEVEL  almost_full asserted when count >= AF_LEVEL
//   AE_LEVEL  almost_empty asserted when count <= AE_LEVEL
//
// Ports:
//   clk           clock, rising edge
//   reset_n       asynchronous active-low reset
//   w_en, din     write request and write data
//   r_en          read request
//   dout          registered read data
//   full, empty, almost_full, almost_empty   status flags
//   count         occupancy, 0..DEPTH
//   clr_err       clear sticky error flags (SYNC_FIFO_ERR_EN only)
//   overflow      sticky: write attempted while full (SYNC_FIFO_ERR_EN only)
//   underflow     sticky: read attempted while empty (SYNC_FIFO_ERR_EN only)
//
// Build option:
//   Define SYNC_FIFO_ERR_EN to add clr_err/overflow/underflow. Without it,
//   rejected requests are dropped silently.

module sync_fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       w_en,
  input  logic [WIDTH-1:0]           din,
  input  logic                       r_en,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef SYNC_FIFO_ERR_EN
  ,
  input  logic                       clr_err,
  output logic                       overflow,
  output logic                       underflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    w_ptr;
  logic [AW-1:0]    r_ptr;

  logic wr_acc;
  logic rd_acc;

  // Acceptance uses the flags as they stand before the edge. A write into a
  // full FIFO is refused even when a read drains an entry on the same edge,
  // and a read from an empty FIFO is refused even when a write lands.
  assign wr_acc = w_en & ~full;
  assign rd_acc = r_en & ~empty;

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // Storage has no reset. Entries become unreachable when the pointers and
  // count are cleared, so their contents do not matter.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[w_ptr] <= din;
    end
  end

  // DEPTH is a power of two, so the pointers wrap from DEPTH-1 to 0 on
  // natural overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_ptr <= '0;
    end else if (wr_acc) begin
      w_ptr <= w_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
      dout  <= '0;
    end else if (rd_acc) begin
      r_ptr <= r_ptr + AW'(1);
      dout  <= mem[r_ptr];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef SYNC_FIFO_ERR_EN
  // The error flags are sticky. A new error on the same edge as clr_err
  // wins, so the flag cannot miss an event that coincides with a clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w_en && full) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (r_en && empty) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - scoreboard testbench for sync_fifo_param

module tb_sync_fifo_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;

  logic             clk;
  logic             reset_n;
  logic             w_en;
  logic [WIDTH-1:0] din;
  logic             r_en;
  logic [WIDTH-1:0] dout;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [4:0]       count;
`ifdef SYNC_FIFO_ERR_EN
  logic             clr_err;
  logic             overflow;
  logic             underflow;
`endif

  sync_fifo_param #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(14), .AE_LEVEL(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .w_en(w_en), .din(din), .r_en(r_en),
    .dout(dout), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count)
`ifdef SYNC_FIFO_ERR_EN
    , .clr_err(clr_err), .overflow(overflow), .underflow(underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] model[$];
  logic [7:0] sb[$];
  logic       rd_issue   = 1'b0;
  logic       rd_pending = 1'b0;
  logic [7:0] last_rd    = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // A read issued on a cycle produces data that is visible one edge later.
  always @(posedge clk) rd_pending <= rd_issue;

  // Monitor: whenever read data is due, compare it against the scoreboard.
  always @(negedge clk) begin
    if (rd_pending) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL rd_data no expected entry actual=%0h", dout);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        if (dout !== e) begin
          failures++;
          $display("FAIL rd_data actual=%0h expected=%0h", dout, e);
        end
      end
    end
  end

  // One clock of stimulus, driven from a falling edge. The reference model
  // decides acceptance from its own occupancy before the edge.
  task automatic step(input logic w, input logic [7:0] d, input logic r);
    logic wr_ok, rd_ok;
    wr_ok = w && (model.size() < DEPTH);
    rd_ok = r && (model.size() > 0);
    w_en = w; din = d; r_en = r;
    rd_issue = rd_ok;
    if (rd_ok) begin
      last_rd = model.pop_front();
      sb.push_back(last_rd);
    end
    if (wr_ok) model.push_back(d);
    @(posedge clk);
    @(negedge clk);
    w_en = 1'b0; r_en = 1'b0; rd_issue = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; w_en = 1'b0; r_en = 1'b0; din = '0;
`ifdef SYNC_FIFO_ERR_EN
    clr_err = 1'b0;
`endif
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_dout", 32'(dout), 32'h00);
    chk("rst_ae", 32'(almost_empty), 32'd1);
    chk("rst_af", 32'(almost_full), 32'd0);

    // A write request on an edge while reset is held is ignored.
    @(negedge clk);
    w_en = 1'b1; din = 8'h99;
    @(negedge clk);
    w_en = 1'b0;
    chk("rst_hold_count", 32'(count), 32'd0);

    // The first edge after release accepts a write.
    reset_n = 1'b1;
    step(1'b1, 8'h5A, 1'b0);
    chk("first_wr_count", 32'(count), 32'd1);
    step(1'b0, 8'h00, 1'b1);
    chk("first_rd_empty", 32'(empty), 32'd1);

    // Fill with 00..0F and then drain, watching the thresholds.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), 1'b0);
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_af", 32'(almost_full), 32'((i + 1) >= 14));
      chk("fill_full", 32'(full), 32'((i + 1) == 16));
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1);
      chk("drain_count", 32'(count), 32'(15 - i));
      chk("drain_ae", 32'(almost_empty), 32'((15 - i) <= 2));
    end
    chk("drain_empty", 32'(empty), 32'd1);
    step(1'b0, 8'h00, 1'b0);
    chk("dout_hold", 32'(dout), 32'h0F);

    // Full FIFO with simultaneous read and write: the write is dropped.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
    chk("full_set", 32'(full), 32'd1);
    step(1'b1, 8'hAA, 1'b1);
    chk("full_rw_count", 32'(count), 32'd15);
`ifdef SYNC_FIFO_ERR_EN
    chk("overflow_set", 32'(overflow), 32'd1);
    chk("underflow_clear", 32'(underflow), 32'd0);
`endif
    for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1);
    chk("after_full_empty", 32'(empty), 32'd1);

    // Empty FIFO with simultaneous read and write: the read is dropped.
    step(1'b1, 8'h55, 1'b1);
    chk("empty_rw_count", 32'(count), 32'd1);
    chk("empty_rw_dout", 32'(dout), 32'h1F);
`ifdef SYNC_FIFO_ERR_EN
    chk("underflow_set", 32'(underflow), 32'd1);
`endif
    step(1'b0, 8'h00, 1'b1);
    chk("empty_rw_after", 32'(empty), 32'd1);
`ifdef SYNC_FIFO_ERR_EN
    // Clearing on the same edge as a new underflow keeps the flag set.
    clr_err = 1'b1;
    step(1'b0, 8'h00, 1'b1);
    chk("clr_priority_uf", 32'(underflow), 32'd1);
    chk("clr_priority_of", 32'(overflow), 32'd0);
    step(1'b0, 8'h00, 1'b0);
    clr_err = 1'b0;
    chk("clr_uf", 32'(underflow), 32'd0);
`endif

    // Steady state at count 8 with continuous simultaneous read and write.
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'(8'h40 + i), 1'b1);
      chk("stream_count", 32'(count), 32'd8);
    end
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);
    chk("stream_empty", 32'(empty), 32'd1);

    // Random traffic, then an asynchronous reset in the middle of a cycle.
    for (int i = 0; i < 24; i++)
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) == 0));
    chk("rand_count", 32'(count), 32'(model.size()));
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_count", 32'(count), 32'd0);
    chk("async_empty", 32'(empty), 32'd1);
    chk("async_full", 32'(full), 32'd0);
    chk("async_dout", 32'(dout), 32'h00);
    model.delete();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    last_rd = 8'h00;
    step(1'b1, 8'hC3, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    chk("post_rst_empty", 32'(empty), 32'd1);
    @(negedge clk);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
